// File: rtl/rmw_accum_ctrl_if.sv
// Request/read-out bus between the update pipeline (master) and the
// read-modify-write accumulator controller (slave).
//
// Handshake: a request (upd_* or rd_*) transfers on a rising clock edge where
// its valid and upd_ready are both high. upd_ready does not depend on the
// valid inputs. A source that sees upd_ready low keeps valid high and holds
// its payload stable until the transfer. When both upd_valid and rd_valid
// are high, only the update transfers. rd_data_valid is a one-cycle strobe
// with no ready; the master must take rd_data on that cycle.
interface rmw_accum_ctrl_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  upd_valid;
    logic                  upd_ready;
    logic [ADDR_WIDTH-1:0] upd_addr;
    logic [WIDTH-1:0]      upd_delta;
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_data_valid;
    logic [WIDTH-1:0]      rd_data;

    modport master (
        output upd_valid, upd_addr, upd_delta, rd_valid, rd_addr,
        input  upd_ready, rd_data_valid, rd_data
    );

    modport slave (
        input  upd_valid, upd_addr, upd_delta, rd_valid, rd_addr,
        output upd_ready, rd_data_valid, rd_data
    );
endinterface

// File: rtl/rmw_accum_ctrl.sv
// Pipelined read-modify-write accumulator controller for a two-port block RAM
// with 2-cycle read latency. Reads on port A, writes on port B, forwards the
// three most recent results so back-to-back updates to one word are exact,
// saturates sums, and can zero-fill the whole RAM.
module rmw_accum_ctrl #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    rmw_accum_ctrl_if.slave       bus,
    input  logic                  clear_start,
    output logic                  busy,
    output logic                  ovf_sticky,
    output logic [ADDR_WIDTH-1:0] ram_address_a,
    output logic [ADDR_WIDTH-1:0] ram_address_b,
    output logic [WIDTH-1:0]      ram_data_a,
    output logic [WIDTH-1:0]      ram_data_b,
    output logic                  ram_wren_a,
    output logic                  ram_wren_b,
    input  logic [WIDTH-1:0]      ram_q_a,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DRAIN = 2'd1, ST_SWEEP = 2'd2} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [WIDTH-1:0]      SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]      SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_addr_q, sweep_addr_d;
    logic                  ovf_q, ovf_d;

    // S1/S2 carry both op kinds; S3..S5 only ever hold update results.
    logic                  s1_valid_q, s1_valid_d, s1_upd_q, s1_upd_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [WIDTH-1:0]      s1_delta_q, s1_delta_d;
    logic                  s2_valid_q, s2_valid_d, s2_upd_q, s2_upd_d;
    logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
    logic [WIDTH-1:0]      s2_delta_q, s2_delta_d;
    logic                  s3_valid_q, s3_valid_d, s4_valid_q, s4_valid_d, s5_valid_q, s5_valid_d;
    logic [ADDR_WIDTH-1:0] s3_addr_q, s3_addr_d, s4_addr_q, s4_addr_d, s5_addr_q, s5_addr_d;
    logic [WIDTH-1:0]      s3_val_q, s3_val_d, s4_val_q, s4_val_d, s5_val_q, s5_val_d;

    logic                  upd_ready, sweep_wr, sweep_entry, pipe_empty;
    logic                  issue, issue_upd;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [WIDTH-1:0]      issue_delta, base, sum;
    logic [WIDTH:0]        sum_ext;
    logic                  sat_hi, sat_lo;

    assign pipe_empty = ~(s1_valid_q | s2_valid_q | s3_valid_q | s4_valid_q | s5_valid_q);

    // Clear FSM state register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Clear FSM next state: wait for the pipeline to empty, then sweep all words.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clear_start) state_d = ST_DRAIN;
            ST_DRAIN: if (pipe_empty)  state_d = ST_SWEEP;
            ST_SWEEP: if (sweep_addr_q == LAST_ADDR) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Clear FSM outputs; rst_n gates upd_ready so nothing issues while in reset.
    always_comb begin
        upd_ready   = rst_n & (state_q == ST_IDLE);
        sweep_wr    = (state_q == ST_SWEEP);
        sweep_entry = (state_q == ST_DRAIN) & (state_d == ST_SWEEP);
        dbg_state   = state_q;
    end

    // Datapath: issue, forwarding, saturating add and RAM/port drive.
    always_comb begin
        issue       = upd_ready & (bus.upd_valid | bus.rd_valid);
        issue_upd   = upd_ready & bus.upd_valid;
        issue_addr  = bus.upd_valid ? bus.upd_addr : bus.rd_addr;
        issue_delta = bus.upd_valid ? bus.upd_delta : '0;

        s1_valid_d = issue;
        s1_upd_d   = issue_upd;
        s1_addr_d  = issue_addr;
        s1_delta_d = issue_delta;
        s2_valid_d = s1_valid_q;
        s2_upd_d   = s1_upd_q;
        s2_addr_d  = s1_addr_q;
        s2_delta_d = s1_delta_q;

        // Newest in-flight result wins; the RAM only holds writes older than S5.
        if (s3_valid_q && s3_addr_q == s2_addr_q)      base = s3_val_q;
        else if (s4_valid_q && s4_addr_q == s2_addr_q) base = s4_val_q;
        else if (s5_valid_q && s5_addr_q == s2_addr_q) base = s5_val_q;
        else                                           base = ram_q_a;

        sum_ext = {base[WIDTH-1], base} + {s2_delta_q[WIDTH-1], s2_delta_q};
        sat_hi  = ~sum_ext[WIDTH] &  sum_ext[WIDTH-1];
        sat_lo  =  sum_ext[WIDTH] & ~sum_ext[WIDTH-1];
        if (sat_hi)      sum = SAT_MAX;
        else if (sat_lo) sum = SAT_MIN;
        else             sum = sum_ext[WIDTH-1:0];

        s3_valid_d = s2_valid_q & s2_upd_q;
        s3_addr_d  = s2_addr_q;
        s3_val_d   = sum;
        s4_valid_d = s3_valid_q;
        s4_addr_d  = s3_addr_q;
        s4_val_d   = s3_val_q;
        s5_valid_d = s4_valid_q;
        s5_addr_d  = s4_addr_q;
        s5_val_d   = s4_val_q;

        ovf_d = sweep_entry ? 1'b0 : (ovf_q | (s2_valid_q & s2_upd_q & (sat_hi | sat_lo)));
        sweep_addr_d = sweep_wr ? sweep_addr_q + ADDR_WIDTH'(1) : '0;

        ram_address_a = issue ? issue_addr : '0;
        ram_data_a    = '0;
        ram_wren_a    = 1'b0;
        ram_wren_b    = s3_valid_q | sweep_wr;
        ram_address_b = s3_valid_q ? s3_addr_q : (sweep_wr ? sweep_addr_q : '0);
        ram_data_b    = s3_valid_q ? s3_val_q : '0;

        bus.upd_ready     = upd_ready;
        bus.rd_data_valid = s2_valid_q & ~s2_upd_q;
        bus.rd_data       = (s2_valid_q & ~s2_upd_q) ? base : '0;
        ovf_sticky        = ovf_q;
        busy = (state_q != ST_IDLE) | issue | ~pipe_empty;
    end

    // Pipeline, sweep counter and sticky overflow registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0; s1_upd_q <= 1'b0; s1_addr_q <= '0; s1_delta_q <= '0;
            s2_valid_q <= 1'b0; s2_upd_q <= 1'b0; s2_addr_q <= '0; s2_delta_q <= '0;
            s3_valid_q <= 1'b0; s3_addr_q <= '0; s3_val_q <= '0;
            s4_valid_q <= 1'b0; s4_addr_q <= '0; s4_val_q <= '0;
            s5_valid_q <= 1'b0; s5_addr_q <= '0; s5_val_q <= '0;
            sweep_addr_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d; s1_upd_q <= s1_upd_d; s1_addr_q <= s1_addr_d; s1_delta_q <= s1_delta_d;
            s2_valid_q <= s2_valid_d; s2_upd_q <= s2_upd_d; s2_addr_q <= s2_addr_d; s2_delta_q <= s2_delta_d;
            s3_valid_q <= s3_valid_d; s3_addr_q <= s3_addr_d; s3_val_q <= s3_val_d;
            s4_valid_q <= s4_valid_d; s4_addr_q <= s4_addr_d; s4_val_q <= s4_val_d;
            s5_valid_q <= s5_valid_d; s5_addr_q <= s5_addr_d; s5_val_q <= s5_val_d;
            sweep_addr_q <= sweep_addr_d;
            ovf_q        <= ovf_d;
        end
    end
endmodule

// File: tb/tb_rmw_accum_ctrl.sv
// Bench for rmw_accum_ctrl: behavioural RAM, an array model of the accumulator
// words, and a per-cycle compare of port-B writes and read-out strobes.
module tb_rmw_accum_ctrl;
    localparam int W = 16;
    localparam int A = 8;
    localparam int D = 256;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    rmw_accum_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(A)) bus ();
    logic          clear_start, busy, ovf_sticky, ram_wren_a, ram_wren_b;
    logic [A-1:0]  ram_address_a, ram_address_b;
    logic [W-1:0]  ram_data_a, ram_data_b, ram_q_a;
    logic [1:0]    dbg_state;

    rmw_accum_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(A)) dut (
        .clock(clock), .rst_n(rst_n), .bus(bus), .clear_start(clear_start),
        .busy(busy), .ovf_sticky(ovf_sticky),
        .ram_address_a(ram_address_a), .ram_address_b(ram_address_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
        .ram_wren_a(ram_wren_a), .ram_wren_b(ram_wren_b),
        .ram_q_a(ram_q_a), .dbg_state(dbg_state)
    );

    // Block RAM: registered address, registered output, write on port B.
    logic [W-1:0] mem [D];
    logic [A-1:0] ram_addr_r;
    logic [W-1:0] ram_q_r;
    assign ram_q_a = ram_q_r;
    always @(posedge clock) begin
        ram_addr_r <= ram_address_a;
        ram_q_r    <= mem[ram_addr_r];
        if (ram_wren_b) mem[ram_address_b] <= ram_data_b;
    end

    // ---------------- model / scoreboard ----------------
    typedef struct { int c; logic [A-1:0] a; logic [W-1:0] d; bit ovf; } wr_t;
    wr_t          wr_q[$];
    wr_t          w_head;
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           ref_mem [D];
    bit           ref_ovf = 0;
    bit           clr_mode = 0;
    bit           chk_en = 0;
    int           sweep_idx = 0;
    int           last_sweep_cyc = 0;
    int           fall_cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_upd(input logic [A-1:0] a, input logic [W-1:0] d);
        int s;
        wr_t w;
        s = ref_mem[a] + int'($signed(d));
        if (s > 32767) begin s = 32767; ref_ovf = 1; end
        else if (s < -32768) begin s = -32768; ref_ovf = 1; end
        ref_mem[a] = s;
        w.c = cyc + 3; w.a = a; w.d = 16'(s); w.ovf = ref_ovf;
        wr_q.push_back(w);
    endtask

    task automatic model_rd(input logic [A-1:0] a);
        exp_q.push_back(16'(ref_mem[a]));
        exp_cyc_q.push_back(cyc + 2);
    endtask

    // Every cycle: port-B writes, read-out strobe, tied-off port A.
    always @(negedge clock) begin
        if (chk_en) begin
            if (wr_q.size() > 0 && wr_q[0].c == cyc) begin
                w_head = wr_q.pop_front();
                chk("wr_en", 32'(ram_wren_b), 32'(1));
                chk("wr_addr", 32'(ram_address_b), 32'(w_head.a));
                chk("wr_data", 32'(ram_data_b), 32'(w_head.d));
                chk("ovf_at_wr", 32'(ovf_sticky), 32'(w_head.ovf));
            end else if (clr_mode && ram_wren_b) begin
                chk("sweep_addr", 32'(ram_address_b), 32'(sweep_idx[7:0]));
                chk("sweep_data", 32'(ram_data_b), 32'(0));
                last_sweep_cyc = cyc;
                sweep_idx++;
                if (sweep_idx == D) clr_mode = 0;
            end else begin
                chk("wr_idle", 32'(ram_wren_b), 32'(0));
            end
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                void'(exp_cyc_q.pop_front());
                chk("rd_valid", 32'(bus.rd_data_valid), 32'(1));
                chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
            end else begin
                chk("rd_idle", 32'(bus.rd_data_valid), 32'(0));
            end
            chk("port_a_tied", 32'({ram_wren_a, ram_data_a}), 32'(0));
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic drive_cycle(input bit uv, input logic [A-1:0] ua, input logic [W-1:0] ud,
                               input bit rv, input logic [A-1:0] ra, input bit cs,
                               output bit took, output int c);
        bus.upd_valid = uv; bus.upd_addr = ua; bus.upd_delta = ud;
        bus.rd_valid = rv; bus.rd_addr = ra; clear_start = cs;
        @(negedge clock);
        took = 0;
        c = cyc;
        if (bus.upd_ready) begin
            if (uv) begin model_upd(ua, ud); took = 1; end
            else if (rv) begin model_rd(ra); took = 1; end
            if (cs) begin
                clr_mode = 1; sweep_idx = 0; ref_ovf = 0;
                for (int i = 0; i < D; i++) ref_mem[i] = 0;
            end
        end
        @(posedge clock); #1;
        bus.upd_valid = 0; bus.rd_valid = 0; clear_start = 0;
    endtask

    task automatic idle(input int n);
        bit t; int c;
        repeat (n) drive_cycle(0, 0, 0, 0, 0, 0, t, c);
    endtask

    task automatic upd(input logic [A-1:0] a, input logic [W-1:0] d);
        bit t; int c;
        drive_cycle(1, a, d, 0, 0, 0, t, c);
        chk("upd_taken", 32'(t), 32'(1));
    endtask

    // Read with a hand-computed expectation at issue+2.
    task automatic rd_lit(input logic [A-1:0] a, input logic [W-1:0] exp, input string nm);
        bit t; int c;
        drive_cycle(0, 0, 0, 1, a, 0, t, c);
        while (cyc < c + 2) begin @(posedge clock); #1; end
        @(negedge clock);
        chk({nm, "_v"}, 32'(bus.rd_data_valid), 32'(1));
        chk(nm, 32'(bus.rd_data), 32'(exp));
        @(posedge clock); #1;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clock);
        while (busy && n < 600) begin @(negedge clock); n++; end
        chk(nm, 32'(busy), 32'(0));
        fall_cyc = cyc;
        @(posedge clock); #1;
    endtask

    task automatic do_clear(input string nm);
        bit t; int c;
        drive_cycle(0, 0, 0, 0, 0, 1, t, c);
        wait_idle(nm);
        chk({nm, "_cnt"}, 32'(sweep_idx), 32'(D));
        chk({nm, "_fall"}, 32'(fall_cyc), 32'(last_sweep_cyc + 1));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit t; int c; int n;
        bus.upd_valid = 0; bus.upd_addr = 0; bus.upd_delta = 0;
        bus.rd_valid = 0; bus.rd_addr = 0; clear_start = 0;
        for (int i = 0; i < D; i++) mem[i] = 16'hDEAD ^ 16'(i);
        for (int i = 0; i < D; i++) ref_mem[i] = 0;

        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(bus.upd_ready), 32'(0));
        chk("rst_outs", 32'({busy, ovf_sticky, ram_wren_b, bus.rd_data_valid}), 32'(0));
        chk("rst_bus", 32'({ram_address_a, ram_address_b, ram_data_b}), 32'(0));
        rst_n = 1;
        #1 chk("rel_ready", 32'(bus.upd_ready), 32'(1));
        @(posedge clock); #1;
        chk_en = 1;

        do_clear("clr0");
        chk("clr0_ovf", 32'(ovf_sticky), 32'(0));

        // Single update then read.
        upd(5, 16'd3);
        idle(4);
        rd_lit(5, 16'd3, "single");

        // Four back-to-back updates, then the same with gaps of 1, 2, 3.
        for (int k = 1; k <= 4; k++) upd(7, 16'(k));
        idle(4);
        rd_lit(7, 16'd10, "b2b");
        for (int g = 1; g <= 3; g++) begin
            for (int k = 1; k <= 4; k++) begin
                upd(8'(10 + g), 16'(k));
                idle(g);
            end
            idle(4);
            rd_lit(8'(10 + g), 16'd10, "gap");
        end

        // Update and read presented together: update first, read next cycle.
        drive_cycle(1, 30, 16'd5, 1, 30, 0, t, c);
        chk("both_upd", 32'(t), 32'(1));
        drive_cycle(0, 0, 0, 1, 30, 0, t, c);
        while (cyc < c + 2) begin @(posedge clock); #1; end
        @(negedge clock);
        chk("both_rd", 32'(bus.rd_data), 32'(16'd5));
        @(posedge clock); #1;

        // Saturation.
        upd(9, 16'd32760);
        upd(9, 16'd100);
        idle(4);
        chk("ovf_set", 32'(ovf_sticky), 32'(1));
        upd(9, 16'h0E90);
        idle(4);
        rd_lit(9, 16'h7FFF, "sat_hi");
        upd(10, 16'h8000);
        upd(10, 16'h8000);
        idle(4);
        rd_lit(10, 16'h8000, "sat_lo");

        // Clear with three ops in flight.
        upd(40, 16'd1);
        upd(41, 16'd2);
        drive_cycle(1, 42, 16'd3, 0, 0, 1, t, c);
        chk("clr_last_op", 32'(t), 32'(1));
        @(negedge clock);
        chk("drain_ready", 32'(bus.upd_ready), 32'(0));
        @(posedge clock); #1;
        wait_idle("clr1");
        chk("clr1_cnt", 32'(sweep_idx), 32'(D));
        chk("clr1_fall", 32'(fall_cyc), 32'(last_sweep_cyc + 1));
        chk("clr1_ovf", 32'(ovf_sticky), 32'(0));
        rd_lit(40, 16'd0, "clr_40");
        rd_lit(9, 16'd0, "clr_9");
        rd_lit(255, 16'd0, "clr_255");

        // A request held through a clear is taken once it finishes.
        drive_cycle(0, 0, 0, 0, 0, 1, t, c);
        n = 0;
        t = 0;
        while (!t && n < 600) begin
            drive_cycle(1, 43, 16'd7, 0, 0, 0, t, c);
            if (n == 0) chk("held_not_taken", 32'(t), 32'(0));
            n++;
        end
        chk("held_taken", 32'(t), 32'(1));
        idle(4);
        rd_lit(43, 16'd7, "held_val");

        // Reset in the middle of a sweep.
        drive_cycle(0, 0, 0, 0, 0, 1, t, c);
        idle(20);
        @(negedge clock);
        chk_en = 0;
        rst_n = 0;
        #1;
        chk("mid_rst_ready", 32'(bus.upd_ready), 32'(0));
        chk("mid_rst_outs", 32'({busy, ovf_sticky, ram_wren_b, bus.rd_data_valid}), 32'(0));
        chk("mid_rst_bus", 32'({ram_address_a, ram_address_b, ram_data_b}), 32'(0));
        wr_q.delete(); exp_q.delete(); exp_cyc_q.delete();
        clr_mode = 0;
        @(posedge clock);
        @(negedge clock);
        rst_n = 1;
        #1 chk("mid_rel_ready", 32'(bus.upd_ready), 32'(1));
        @(posedge clock); #1;
        chk_en = 1;
        do_clear("clr2");
        rd_lit(100, 16'd0, "clr2_100");
        upd(100, 16'hFFFE);
        idle(4);
        rd_lit(100, 16'hFFFE, "neg_val");

        idle(4);
        chk("wr_drained", 32'(wr_q.size()), 32'(0));
        chk("rd_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
